// File: rtl/seq_game_pkg.sv
// Shared types and helpers for the memory-game round controller.
package seq_game_pkg;

  localparam int SYM_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW_ON,
    SHOW_OFF,
    INPUT,
    WIN,
    FAIL
  } state_e;

  // Map a 2-bit colour symbol to its LED/button bit.
  function automatic logic [3:0] sym_to_onehot(input logic [SYM_W-1:0] sym);
    sym_to_onehot = 4'b0001 << sym;
  endfunction

  // Largest of three cycle counts, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_game_ctrl_mem.sv
// Symbol store for the current sequence: one synchronous write port used
// when a symbol is appended, one asynchronous read port for playback/check.
module seq_mem
  import seq_game_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [SYM_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [SYM_W-1:0] rdata
);

  logic [SYM_W-1:0] mem [DEPTH];

  // Contents are only meaningful below the current length, so no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/seq_game_ctrl.sv
// Round controller: grows a pseudo-random colour sequence by one symbol per
// round, plays it back on the LEDs, then checks the player's presses.
module seq_game_ctrl
  import seq_game_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [9:0]                     lfsr,
  input  logic                           start,
  input  logic [3:0]                     btn,
  output logic [3:0]                     led,
  output logic [$clog2(MAX_LEN+1)-1:0]   score,
  output logic                           busy,
  output logic                           win,
  output logic                           fail
);

  localparam int SW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);

  state_e           state;
  state_e           state_n;
  logic [SW-1:0]    len;
  logic [SW-1:0]    idx;
  logic [TW-1:0]    timer;
  logic [SYM_W-1:0] cur_sym;
  logic             hit;
  logic             last;
  logic             show_done;
  logic             gap_done;
  logic             tout_done;
  logic             unused_lfsr_bits;

  // Only the low symbol bits of the LFSR feed the game.
  assign unused_lfsr_bits = ^lfsr[9:SYM_W];

  seq_mem #(
    .DEPTH(MAX_LEN),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (state == ADD),
    .waddr(len[AW-1:0]),
    .wdata(lfsr[SYM_W-1:0]),
    .raddr(idx[AW-1:0]),
    .rdata(cur_sym)
  );

  // A multi-bit press can never equal a one-hot colour, so it misses too.
  assign hit       = (btn == sym_to_onehot(cur_sym));
  assign last      = (idx == len - SW'(1));
  assign show_done = (timer == TW'(SHOW_CYCLES - 1));
  assign gap_done  = (timer == TW'(GAP_CYCLES - 1));
  assign tout_done = (timer == TW'(TIMEOUT_CYCLES - 1));

  // LEDs are lit only while a playback step is in its visible phase.
  always_comb begin
    led = '0;
    if (state == SHOW_ON) led = sym_to_onehot(cur_sym);
  end

  // Next-state selection for the round sequencer.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, WIN, FAIL: if (start) state_n = ADD;
      ADD:             state_n = SHOW_ON;
      SHOW_ON:         if (show_done) state_n = SHOW_OFF;
      SHOW_OFF:        if (gap_done) state_n = last ? INPUT : SHOW_ON;
      INPUT: begin
        if (btn == '0) begin
          if (tout_done) state_n = FAIL;
        end else if (!hit) begin
          state_n = FAIL;
        end else if (last) begin
          state_n = (len == SW'(MAX_LEN)) ? WIN : ADD;
        end
      end
      default:         state_n = IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      len   <= '0;
      idx   <= '0;
      timer <= '0;
      score <= '0;
      busy  <= 1'b0;
      win   <= 1'b0;
      fail  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= !(state_n inside {IDLE, WIN, FAIL});
      win   <= (state_n == WIN);
      fail  <= (state_n == FAIL);
      case (state)
        IDLE, WIN, FAIL: begin
          if (start) begin
            len   <= '0;
            idx   <= '0;
            score <= '0;
          end
        end
        ADD: begin
          len   <= len + SW'(1);
          idx   <= '0;
          timer <= '0;
        end
        SHOW_ON: begin
          timer <= show_done ? '0 : timer + TW'(1);
        end
        SHOW_OFF: begin
          if (gap_done) begin
            timer <= '0;
            idx   <= last ? '0 : idx + SW'(1);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        INPUT: begin
          if (btn == '0) begin
            timer <= timer + TW'(1);
          end else begin
            timer <= '0;
            if (hit) begin
              if (last) score <= score + SW'(1);
              else      idx   <= idx + SW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
